// File: rtl/flipper_key_filter.sv
// flipper_key_filter
//   Per-frame debounce and arbitration of keypad codes into clean left/right
//   move requests for flipper_controller. A key must be held for
//   DEBOUNCE_FRAMES sampled frames before its request asserts. After a request
//   ends, RELEASE_FRAMES consecutive key-free frames are needed before any new
//   press is accepted, so the flipper can never reverse inside one frame.
//
// Ports
//   clk            system clock
//   resetN         asynchronous active-low reset
//   startOfFrame   one-cycle pulse per video frame; the only sampling instant
//   keyCode[3:0]   current keypad code, meaningful only while keyValid=1
//   keyValid       level: a key is currently held
//   pause          freezes state, counter and outputs; frames are dropped
//   reset_level    synchronous return to IDLE; beats pause and startOfFrame
//   key4IsPressed  debounced left request (registered level)
//   key6IsPressed  debounced right request (registered level)
//   pressPulse     one-cycle pulse on entering a HOLD state

module flipper_key_filter #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned RELEASE_FRAMES  = 1,
  parameter logic [3:0]  KEY_LEFT        = 4'h4,
  parameter logic [3:0]  KEY_RIGHT       = 4'h6
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic [3:0] keyCode,
  input  logic       keyValid,
  input  logic       pause,
  input  logic       reset_level,
  output logic       key4IsPressed,
  output logic       key6IsPressed,
  output logic       pressPulse
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM_L   = 3'd1,
    ARM_R   = 3'd2,
    HOLD_L  = 3'd3,
    HOLD_R  = 3'd4,
    RELEASE = 3'd5
  } state_t;

  // Thresholds are compared against a 5-bit increment so cnt+1 can be
  // tested without the 4-bit counter ever wrapping.
  localparam logic [4:0] DEB_LIMIT = 5'(DEBOUNCE_FRAMES);
  localparam logic [4:0] REL_LIMIT = 5'(RELEASE_FRAMES);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_cnt;
  logic [3:0] w_nextCnt;
  logic [4:0] w_cntInc;
  logic       w_rawL;
  logic       w_rawR;
  logic       w_holdNext;
  logic       w_holdNow;
  logic       r_key4;
  logic       r_key6;
  logic       r_pulse;

  // Codes other than the two move keys count as "no key".
  assign w_rawL   = keyValid && (keyCode == KEY_LEFT);
  assign w_rawR   = keyValid && (keyCode == KEY_RIGHT);
  assign w_cntInc = {1'b0, r_cnt} + 5'd1;

  // Next-state logic. reset_level wins over everything; pause freezes the
  // machine so a frame arriving during pause is simply lost.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    if (reset_level) begin
      w_nextState = IDLE;
      w_nextCnt   = 4'd0;
    end else if (!pause && startOfFrame) begin
      unique case (r_state)
        IDLE: begin
          if (w_rawL) begin
            if (DEB_LIMIT == 5'd1) begin
              w_nextState = HOLD_L;
              w_nextCnt   = 4'd0;
            end else begin
              w_nextState = ARM_L;
              w_nextCnt   = 4'd1;
            end
          end else if (w_rawR) begin
            if (DEB_LIMIT == 5'd1) begin
              w_nextState = HOLD_R;
              w_nextCnt   = 4'd0;
            end else begin
              w_nextState = ARM_R;
              w_nextCnt   = 4'd1;
            end
          end
        end
        ARM_L: begin
          if (w_rawL) begin
            if (w_cntInc == DEB_LIMIT) begin
              w_nextState = HOLD_L;
              w_nextCnt   = 4'd0;
            end else begin
              w_nextCnt = w_cntInc[3:0];
            end
          end else begin
            w_nextState = IDLE;
            w_nextCnt   = 4'd0;
          end
        end
        ARM_R: begin
          if (w_rawR) begin
            if (w_cntInc == DEB_LIMIT) begin
              w_nextState = HOLD_R;
              w_nextCnt   = 4'd0;
            end else begin
              w_nextCnt = w_cntInc[3:0];
            end
          end else begin
            w_nextState = IDLE;
            w_nextCnt   = 4'd0;
          end
        end
        HOLD_L: begin
          if (!w_rawL) begin
            w_nextState = RELEASE;
            w_nextCnt   = 4'd0;
          end
        end
        HOLD_R: begin
          if (!w_rawR) begin
            w_nextState = RELEASE;
            w_nextCnt   = 4'd0;
          end
        end
        RELEASE: begin
          // Any move key during the gap restarts it, blocking reversal.
          if (w_rawL || w_rawR) begin
            w_nextCnt = 4'd0;
          end else if (w_cntInc == REL_LIMIT) begin
            w_nextState = IDLE;
            w_nextCnt   = 4'd0;
          end else begin
            w_nextCnt = w_cntInc[3:0];
          end
        end
        default: begin
          w_nextState = IDLE;
          w_nextCnt   = 4'd0;
        end
      endcase
    end
  end

  assign w_holdNext = (w_nextState == HOLD_L) || (w_nextState == HOLD_R);
  assign w_holdNow  = (r_state == HOLD_L) || (r_state == HOLD_R);

  // State, counter and registered outputs. Outputs are decoded from the
  // next state so they line up with the state register; while paused the
  // next state equals the current one, so the levels hold and no pulse fires.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_key4  <= 1'b0;
      r_key6  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_key4  <= (w_nextState == HOLD_L);
      r_key6  <= (w_nextState == HOLD_R);
      r_pulse <= w_holdNext && !w_holdNow;
    end
  end

  assign key4IsPressed = r_key4;
  assign key6IsPressed = r_key6;
  assign pressPulse    = r_pulse;

endmodule
